// File: rtl/button_conditioner.sv
// Five-button conditioner: 2-FF synchronizer, per-button debounce, press/release
// pulses, long-press level and masked auto-repeat.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_RATE     = 10000000,
  parameter logic [4:0]  REPEAT_MASK     = 5'b00011
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] btn_in,
  output logic [4:0] btn_level,
  output logic [4:0] btn_press,
  output logic [4:0] btn_release,
  output logic [4:0] btn_repeat,
  output logic [4:0] btn_long
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HW = $clog2(REPEAT_DELAY + 1);
  localparam int unsigned RW = $clog2(REPEAT_RATE + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(REPEAT_DELAY);
  localparam logic [HW-1:0] HOLD_FIRE = HW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);

  logic [4:0]    sync1, sync2;
  logic [4:0]    level_q, press_q, rel_q, rpt_q, long_q;
  logic [4:0]    level_d, press_d, rel_d, rpt_d, long_d;
  logic [4:0]    toggle, fire_first, fire_rate;
  logic [DW-1:0] db_cnt   [5];
  logic [DW-1:0] db_d     [5];
  logic [HW-1:0] hold_cnt [5];
  logic [HW-1:0] hold_d   [5];
  logic [RW-1:0] rate_cnt [5];
  logic [RW-1:0] rate_d   [5];

  always_comb begin
    toggle     = '0;
    fire_first = '0;
    fire_rate  = '0;
    level_d    = '0;
    press_d    = '0;
    rel_d      = '0;
    rpt_d      = '0;
    long_d     = '0;
    for (int i = 0; i < 5; i++) begin
      db_d[i]   = '0;
      hold_d[i] = '0;
      rate_d[i] = '0;
    end

    for (int i = 0; i < 5; i++) begin
      if (sync2[i] != level_q[i]) begin
        if (db_cnt[i] == DB_LAST) begin
          toggle[i] = 1'b1;
        end else begin
          db_d[i] = db_cnt[i] + DW'(1);
        end
      end

      level_d[i] = level_q[i] ^ toggle[i];
      press_d[i] = toggle[i] & ~level_q[i];
      rel_d[i]   = toggle[i] & level_q[i];

      // Hold count is 0 in the press cycle and saturates at REPEAT_DELAY.
      if (level_q[i] && level_d[i]) begin
        hold_d[i] = (hold_cnt[i] == HOLD_MAX) ? hold_cnt[i] : hold_cnt[i] + HW'(1);
      end
      long_d[i] = level_d[i] && (hold_d[i] == HOLD_MAX);

      fire_first[i] = level_q[i] && level_d[i] && (hold_cnt[i] == HOLD_FIRE);
      fire_rate[i]  = long_q[i] && (rate_cnt[i] == RATE_LAST);

      // level_d gating drops a repeat that lands on the release edge.
      rpt_d[i] = REPEAT_MASK[i] && level_d[i] && (fire_first[i] || fire_rate[i]);

      if (long_q[i] && !fire_rate[i]) begin
        rate_d[i] = rate_cnt[i] + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      rpt_q   <= '0;
      long_q  <= '0;
      for (int i = 0; i < 5; i++) begin
        db_cnt[i]   <= '0;
        hold_cnt[i] <= '0;
        rate_cnt[i] <= '0;
      end
    end else begin
      sync1   <= btn_in;
      sync2   <= sync1;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      rpt_q   <= rpt_d;
      long_q  <= long_d;
      for (int i = 0; i < 5; i++) begin
        db_cnt[i]   <= db_d[i];
        hold_cnt[i] <= hold_d[i];
        rate_cnt[i] <= rate_d[i];
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = rel_q;
  assign btn_repeat  = rpt_q;
  assign btn_long    = long_q;

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the number of stable synchronized cycles required to accept a level change (10 ms at 100 MHz).
REQ-002 SHALL have parameter REPEAT_DELAY, default 50000000, meaning the number of held cycles from press to the first auto-repeat and to long-press detection.
REQ-003 SHALL have parameter REPEAT_RATE, default 10000000, meaning the number of cycles between subsequent auto-repeat pulses.
REQ-004 SHALL have parameter REPEAT_MASK, default 5'b00011, meaning the buttons allowed to auto-repeat (up and down only).
REQ-005 SHALL have port clk, input, 1 bit: the single board clock, used for all state.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port btn_in, input, 5 bits: raw asynchronous button pins, mapped bit0 up, bit1 down, bit2 left, bit3 right, bit4 middle, active-high.
REQ-008 SHALL have port btn_level, output, 5 bits: debounced button state.
REQ-009 SHALL have port btn_press, output, 5 bits: one-cycle pulse per button on an accepted press.
REQ-010 SHALL have port btn_release, output, 5 bits: one-cycle pulse per button on an accepted release.
REQ-011 SHALL have port btn_repeat, output, 5 bits: one-cycle auto-repeat pulse per button.
REQ-012 SHALL have port btn_long, output, 5 bits: level per button, high while held at least REPEAT_DELAY cycles.

Function
REQ-013 SHALL pass each btn_in bit through a 2-FF synchronizer; the stage-2 value is s.
REQ-014 SHALL keep one debounce counter per button, cleared whenever s equals btn_level and incremented whenever s differs.
REQ-015 SHALL toggle btn_level on the clock edge where the counter equals DEBOUNCE_CYCLES-1 while s still differs, and clear the counter on that same edge.
REQ-016 SHALL therefore change btn_level exactly 2+DEBOUNCE_CYCLES cycles after btn_in settles; any glitch shorter than DEBOUNCE_CYCLES SHALL produce no output change.
REQ-017 SHALL assert btn_press in the first cycle btn_level is 1, and btn_release in the first cycle btn_level is 0; both are registered and one cycle wide.
REQ-018 SHALL keep one hold counter per button: cleared while btn_level is 0, incremented from the press cycle while btn_level is 1, saturating (never wrapping).
REQ-019 SHALL assert btn_long REPEAT_DELAY cycles after the btn_press cycle and hold it until the cycle btn_level falls; btn_long clears in the same cycle btn_release pulses.
REQ-020 SHALL, for buttons in REPEAT_MASK only, pulse btn_repeat at press+REPEAT_DELAY and then every REPEAT_RATE cycles while held; a separate repeat-interval counter provides this, so hold-counter saturation does not stop repeats.
REQ-021 SHALL never pulse btn_repeat for buttons outside REPEAT_MASK; btn_long still operates for those buttons.
REQ-022 SHALL process the five buttons fully independently; simultaneous presses and releases SHALL produce coincident pulses on each affected bit.
REQ-023 SHALL size all counters by $clog2 of the largest parameter they reach, with no truncation.
REQ-024 SHALL, on a release accepted in the same cycle a repeat would fire, suppress the repeat and emit only btn_release.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force all synchronizer flops, counters, btn_level, btn_press, btn_release, btn_repeat and btn_long to 0.
REQ-026 SHALL, on reset deassertion with a button held, treat the button as a new press: btn_press fires 2+DEBOUNCE_CYCLES cycles after rst_n rises.
REQ-027 SHALL leave no pulse pending across a reset asserted mid-hold.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5)
REQ-028 SHALL cover bounce: up toggling 3 cycles high / 1 low for 20 cycles, then steady high -> no output change during the toggling, then btn_press[0] exactly 6 cycles after the last edge.
REQ-029 SHALL cover auto-repeat: hold up for 40 cycles after the press -> btn_long[0] rises at press+20; btn_repeat[0] pulses at press+20, +25, +30, +35.
REQ-030 SHALL cover masked button: hold left for 30 cycles -> btn_long[2] rises at press+20; btn_repeat[2] stays 0 throughout.
REQ-031 SHALL cover release: drop up after a long hold -> 6 cycles later btn_release[0] pulses, btn_level[0] and btn_long[0] fall in that same cycle, and no further repeats occur.
REQ-032 SHALL cover reset mid-hold: assert rst_n=0 with up held -> all outputs 0 immediately without waiting for a clock; rst_n=1 with up still held -> btn_press[0] 6 cycles later.
REQ-033 SHALL cover simultaneous press: up and down rise in the same cycle -> btn_press[0] and btn_press[1] pulse in the same cycle, and their repeat pulses coincide.
